// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } fetch_state_t;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Legal fetch address: word aligned and inside the instruction memory.
    function automatic logic pc_legal(input logic [31:0] addr, input logic [31:0] limit);
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: instruction memory port, control inputs and decode handshake.
interface fetch_controller_if;

    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
    logic        fault;

    modport master (
        output imem_address, out_valid, out_instruction, out_pc, out_pc_plus4, halted, fault,
        input  imem_instruction, redirect, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_address, out_valid, out_instruction, out_pc, out_pc_plus4, halted, fault,
        output imem_instruction, redirect, redirect_pc, halt, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {instruction, pc} pairs with flush; push while full is legal only alongside a pop.
module fetch_fifo
    import fetch_controller_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entries [FIFO_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        do_pop  = pop && (count != 2'd0);
        // When full, tail aliases head, so overwriting it is safe only as the head leaves.
        do_push = push && ((count != 2'(FIFO_DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= din;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, feeds a 2-entry buffer toward decode,
// and handles redirects, halt requests and fetch faults.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 128
)(
    input  logic              clk,
    input  logic              rst_n,
    fetch_controller_if.master bus
);

    localparam logic [31:0] PC_LIMIT = 32'(WORD_BYTES * IMEM_WORDS);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t din;
    logic         push;
    logic         pop;
    logic         flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = bus.out_valid && bus.out_ready;
        case (state)
            ST_FAULT: begin
            end
            default: begin
                if (bus.redirect) begin
                    // Flush beats any same-cycle pop; the target loads even when it faults.
                    flush      = 1'b1;
                    pop        = 1'b0;
                    pc_next    = bus.redirect_pc;
                    state_next = pc_legal(bus.redirect_pc, PC_LIMIT) ? ST_FETCH : ST_FAULT;
                end else if (state == ST_HALTED) begin
                    if (!bus.halt) begin
                        state_next = ST_FETCH;
                    end
                end else if (bus.halt) begin
                    state_next = ST_HALTED;
                end else if (pc >= PC_LIMIT) begin
                    state_next = ST_FAULT;
                end else if ((count != 2'(FIFO_DEPTH)) || pop) begin
                    push    = 1'b1;
                    pc_next = pc + 32'(WORD_BYTES);
                end
            end
        endcase
    end

    assign din = '{instr: bus.imem_instruction, pc: pc};

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .count (count),
        .head  (head)
    );

    assign bus.imem_address    = pc;
    assign bus.out_valid       = (count != 2'd0);
    assign bus.out_instruction = head.instr;
    assign bus.out_pc          = head.pc;
    assign bus.out_pc_plus4    = head.pc + 32'(WORD_BYTES);
    assign bus.halted          = (state == ST_HALTED);
    assign bus.fault           = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a 128-word memory holding word i = 3*i.
module tb_fetch_controller;

    localparam int unsigned IMEM_WORDS = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] mem [IMEM_WORDS];

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_instruction = mem[bus.imem_address[8:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".pc"}, bus.out_pc, pc);
        chk({tag, ".instr"}, bus.out_instruction, instr);
        chk({tag, ".pc4"}, bus.out_pc_plus4, pc + 32'd4);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst_n           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.out_ready   = rdy;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'(3 * i);
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.out_ready   = 1'b1;
        #1;

        // Reset values and streaming with ready held high
        do_reset(1'b1);
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.instr", bus.out_instruction, 32'd0);
        chk("rst.pc", bus.out_pc, 32'd0);
        chk("rst.pc4", bus.out_pc_plus4, 32'd4);
        chk("rst.halted", 32'(bus.halted), 32'd0);
        chk("rst.fault", 32'(bus.fault), 32'd0);
        chk("rst.addr", bus.imem_address, 32'd0);
        tick; chk_head("stream0", 32'h0, 32'd0);
        tick; chk_head("stream1", 32'h4, 32'd3);
        tick; chk_head("stream2", 32'h8, 32'd6);

        // Stall with ready low: fills in two cycles, head stable, PC holds
        do_reset(1'b0);
        tick; chk("stall1.addr", bus.imem_address, 32'h4);
        tick; chk("stall2.addr", bus.imem_address, 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall.hold.addr", bus.imem_address, 32'h8);
            chk_head("stall.hold", 32'h0, 32'd0);
        end
        bus.out_ready = 1'b1;
        tick; chk_head("drain1", 32'h4, 32'd3);
        tick; chk_head("drain2", 32'h8, 32'd6);
        chk("drain2.addr", bus.imem_address, 32'h10);

        // Redirect while full discards the buffered entries
        do_reset(1'b0);
        tick; tick;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
        tick;
        chk("redir.valid", 32'(bus.out_valid), 32'd0);
        chk("redir.addr", bus.imem_address, 32'h40);
        chk("redir.fault", 32'(bus.fault), 32'd0);
        bus.redirect = 1'b0;
        tick; chk_head("redir.head", 32'h40, 32'd48);
        bus.out_ready = 1'b1;
        tick; chk_head("redir.next", 32'h44, 32'd51);

        // Halt for four cycles: drains, PC frozen, then resumes at the frozen PC
        bus.halt = 1'b1; bus.out_ready = 1'b0;
        tick;
        chk("halt1.halted", 32'(bus.halted), 32'd1);
        chk_head("halt1", 32'h44, 32'd51);
        chk("halt1.addr", bus.imem_address, 32'h48);
        bus.out_ready = 1'b1;
        tick;
        chk("halt2.valid", 32'(bus.out_valid), 32'd0);
        chk("halt2.addr", bus.imem_address, 32'h48);
        tick; tick;
        chk("halt4.halted", 32'(bus.halted), 32'd1);
        chk("halt4.addr", bus.imem_address, 32'h48);
        bus.halt = 1'b0;
        tick;
        chk("unhalt.halted", 32'(bus.halted), 32'd0);
        chk("unhalt.valid", 32'(bus.out_valid), 32'd0);
        tick;
        chk_head("resume", 32'h48, 32'd54);
        chk("resume.addr", bus.imem_address, 32'h4C);

        // Redirect leaves HALTED even with halt held; halt re-applies next cycle
        bus.halt = 1'b1;
        tick; chk("h2.halted", 32'(bus.halted), 32'd1);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h10;
        tick;
        chk("hredir.halted", 32'(bus.halted), 32'd0);
        chk("hredir.addr", bus.imem_address, 32'h10);
        bus.redirect = 1'b0;
        tick;
        chk("hredir2.halted", 32'(bus.halted), 32'd1);
        chk("hredir2.valid", 32'(bus.out_valid), 32'd0);
        chk("hredir2.addr", bus.imem_address, 32'h10);
        bus.halt = 1'b0;

        // Misaligned redirect faults; later redirect ignored; async reset clears
        bus.out_ready = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h42;
        tick;
        chk("mis.fault", 32'(bus.fault), 32'd1);
        chk("mis.addr", bus.imem_address, 32'h42);
        chk("mis.valid", 32'(bus.out_valid), 32'd0);
        bus.redirect_pc = 32'h40;
        tick;
        chk("mis.ign.fault", 32'(bus.fault), 32'd1);
        chk("mis.ign.addr", bus.imem_address, 32'h42);
        bus.redirect = 1'b0;
        tick; tick;
        chk("mis.idle.valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst.fault", 32'(bus.fault), 32'd0);
        chk("arst.addr", bus.imem_address, 32'h0);
        chk("arst.valid", 32'(bus.out_valid), 32'd0);
        #1;
        rst_n = 1'b1;

        // Out-of-range redirect faults
        tick;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        tick;
        chk("oor.fault", 32'(bus.fault), 32'd1);
        chk("oor.addr", bus.imem_address, 32'h200);
        chk("oor.valid", 32'(bus.out_valid), 32'd0);
        bus.redirect = 1'b0;

        // Running off the end of memory
        do_reset(1'b0);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h1F8;
        tick;
        bus.redirect = 1'b0;
        tick; tick;
        chk("end.addr", bus.imem_address, 32'h200);
        chk("end.fault0", 32'(bus.fault), 32'd0);
        tick;
        chk("end.fault1", 32'(bus.fault), 32'd1);
        chk_head("end.head0", 32'h1F8, 32'd378);
        bus.out_ready = 1'b1;
        tick; chk_head("end.head1", 32'h1FC, 32'd381);
        tick; chk("end.drained", 32'(bus.out_valid), 32'd0);
        tick;
        chk("end.still", 32'(bus.out_valid), 32'd0);
        chk("end.sticky", 32'(bus.fault), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the single-cycle/pipelined MIPS datapath. It owns the program counter, drives the word address into the 128-word combinational instruction memory, and buffers fetched instructions in a 2-entry FIFO toward decode with a valid/ready handshake. It handles branch/jump redirects by flushing, supports a halt request, and reports fetch faults for misaligned or out-of-range PCs.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_WORDS, 128, instruction memory depth in words; the legal PC range is 0 .. 4*IMEM_WORDS-4.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- IMemAddress  out  32  byte address to instruction memory; equals the PC register.
- IMemInstruction  in  32  combinational read data for IMemAddress, valid in the same cycle.
- Redirect  in  1  one-cycle pulse: load RedirectPC and flush the buffer.
- RedirectPC  in  32  redirect target byte address.
- Halt  in  1  level: stop issuing new fetches.
- OutValid  out  1  FIFO head is valid.
- OutReady  in  1  decode accepts the head this cycle.
- OutInstruction  out  32  head instruction.
- OutPC  out  32  byte address of the head instruction.
- OutPCPlus4  out  32  OutPC + 4.
- Halted  out  1  high in the HALTED state.
- Fault  out  1  sticky fault flag.

## Operation
- States: FETCH, HALTED, FAULT. Reset enters FETCH.
- Push condition (FETCH only): no Redirect, no Halt, PC in range, and (count < 2 or pop this cycle).
  - On a push, the FIFO stores {IMemInstruction, PC} and PC <= PC + 4.
- Pop condition: OutValid && OutReady. This removes the head. A simultaneous push and pop keeps count unchanged.
- FIFO: 2 entries, count 0..2, wrap-around head/tail pointers. OutValid = (count != 0). OutInstruction, OutPC and OutPCPlus4 come from the head entry.
- Redirect has top priority, in any state except FAULT:
  - Flush the FIFO (count <= 0) and PC <= RedirectPC.
  - Go to FETCH, even from HALTED and even while Halt is asserted. Halt re-applies the next cycle.
  - No push occurs that cycle. A pop in the same cycle is ignored, because the flush wins.
  - If RedirectPC[1:0] != 0 or RedirectPC >= 4*IMEM_WORDS, go to FAULT instead; PC still loads the target.
- Halt in FETCH (and no Redirect): no push; go to HALTED. The FIFO keeps draining through pops. HALTED returns to FETCH when Halt deasserts.
- PC in range check, in FETCH: if PC >= 4*IMEM_WORDS, go to FAULT with no push. This covers running off the end of memory.
- FAULT: Fault = 1, no pushes, Redirect ignored, FIFO drains normally. Only Reset_n leaves FAULT.
- PC arithmetic is 32-bit modulo. IMemAddress[1:0] is always 0 in FETCH.

## Timing
- Reset values: PC = RESET_PC, count = 0, OutValid = 0, OutInstruction = 0, OutPC = 0, OutPCPlus4 = 4, Halted = 0, Fault = 0, state = FETCH.
- Latency: an instruction read at cycle n is visible at the head (OutValid = 1) in cycle n+1.
- Throughput: 1 instruction per cycle while OutReady is held high.
- Redirect asserted in cycle n: the first instruction from the target is at the head in cycle n+2.
- Stall: with OutReady = 0, the FIFO fills in 2 cycles; then PC holds.
- Output stability: while OutValid = 1 and OutReady = 0, the head contents must stay stable.
- Reset_n asserted mid-operation clears everything immediately (asynchronous); the FIFO contents are discarded.

## Structure
- Shared package: state encoding (FETCH = 2'd0, HALTED = 2'd1, FAULT = 2'd2), FIFO depth constant (2), word-size constant (4).
- One sub-module: fetch_fifo, a 2-entry, 64-bit-wide synchronous FIFO with push, pop, flush, count and head outputs.
- PC register, range/alignment checks and the state machine stay in fetch_controller.
- Instruction memory is external and is instantiated alongside this block in the fetch stage.

## Test plan
Memory is initialised with word i = 3*i.
- Reset, OutReady = 1 -> OutValid rises in the 2nd cycle. The head sequence is (OutPC, OutInstruction) = (0, 0), (4, 3), (8, 6), one per cycle, with OutPCPlus4 = OutPC + 4.
- OutReady = 0 for 5 cycles after reset -> count saturates at 2 and the PC holds at 8. Releasing OutReady -> instructions 0, 3, 6 are delivered in order, with no drops or duplicates.
- Redirect to 0x40 while the FIFO is full -> the next head after the flush is (0x40, 48). Previously buffered entries never appear.
- Halt for 4 cycles -> Halted = 1, the FIFO drains, IMemAddress is frozen. Halt deasserted -> fetch resumes at the frozen PC.
- Redirect to 0x42, and separately to 0x200 -> Fault = 1 sticky, no further OutValid after the drain, and a later Redirect is ignored. Assert Reset_n low -> Fault = 0 and PC = 0.
- Run sequentially to PC = 0x1FC -> the instruction at 0x1FC (381) is delivered, then Fault asserts when PC = 0x200.
